arbitro_leituras_rr: RTL
========================

# arbitro_leituras_rr

Round-robin read arbiter between `NUM_EA` approved-expander requesters and a bank of `NUM_READ_PORTS` memory read ports.
- Each cycle, one requester is granted; its full address vector is registered to memory.
- The returned data is tagged with the winner's index after a configurable memory latency.
- Multiple reads stay in flight at once.
- Sits between the expanders and the memory blocks; replaces the single-outstanding, fixed-priority read manager.

## Interface
Parameters:
- `NUM_READ_PORTS`, 8, read ports served per grant
- `NUM_EA`, 8, number of requesters (≥2)
- `DATA_WIDTH`, 32, data bits per port
- `ADDR_WIDTH`, 8, address bits per port
- `MEM_LATENCY`, 1, cycles from `mem_read_en_out` to valid `mem_read_data_in` (≥1)
- `ID_WIDTH`, $clog2(NUM_EA), derived localparam; not overridable

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `read_en_in`  in  NUM_EA  per-requester read request; held until granted
- `read_addr_in`  in  ADDR_WIDTH*NUM_READ_PORTS*NUM_EA  requester k's vector at slice [k*AW*NP +: AW*NP]
- `grant_out`  out  NUM_EA  one-hot, one-cycle grant pulse
- `read_addr_out`  out  ADDR_WIDTH*NUM_READ_PORTS  registered address vector of the winner
- `mem_read_en_out`  out  1  address vector valid this cycle
- `mem_read_data_in`  in  DATA_WIDTH*NUM_READ_PORTS  memory read data
- `read_data_out`  out  DATA_WIDTH*NUM_READ_PORTS  returned data, shared by all requesters
- `data_valid_out`  out  NUM_EA  one-hot; `read_data_out` belongs to the flagged requester
- `read_id_out`  out  ID_WIDTH  binary index of the returned requester

## Operation
**Reset.** While `rst` is high at a clock edge:
- All outputs and registers go to 0.
- The round-robin pointer goes to 0.
- The in-flight pipeline is cleared.
- Reads issued before reset never produce `data_valid_out`.

**Eligibility.** Requester k is eligible when `read_en_in[k]`=1 and `grant_out[k]`=0. The second condition blocks a double grant on the cycle the requester sees its grant.

**Arbitration.** Combinational round-robin over eligible requesters.
- Search starts at pointer p and proceeds p, p+1, …, NUM_EA-1, 0, …, p-1.
- The first eligible requester wins.
- After a grant to k, p ← (k+1) mod NUM_EA.
- With no eligible requester, p is held.

**Issue.** On a grant to k, at the same edge:
- `grant_out` ← one-hot(k).
- `read_addr_out` ← slice k of `read_addr_in`.
- `mem_read_en_out` ← 1.

With no eligible requester, `grant_out` and `mem_read_en_out` go to 0 and `read_addr_out` holds its value.

**Return pipeline.** A shift register of depth `MEM_LATENCY` carries {valid, id}. At most one entry is inserted per cycle, so up to `MEM_LATENCY` reads are outstanding. When an entry exits with valid=1:
- `data_valid_out[id]` = 1.
- `read_id_out` = id.

**Data path.** `read_data_out` is `mem_read_data_in` passed straight through (see Configuration).

**Requester contract.**
- Drop `read_en_in` or change the address in the cycle `grant_out[k]` is seen.
- Addresses must be stable while `read_en_in` is high and ungranted.

## Timing
- Request sampled at edge t → `grant_out`/`read_addr_out`/`mem_read_en_out` valid in cycle t+1.
- `data_valid_out` is asserted in cycle t+1+`MEM_LATENCY`, coincident with memory data.
- Throughput: one grant per cycle across requesters.
- A single requester holding `read_en_in` high is granted at most every other cycle.
- With all NUM_EA requesting continuously, each is granted exactly once per NUM_EA cycles.
- No back-pressure: requesters must accept `data_valid_out` unconditionally.
- Pointer wrap: a grant to NUM_EA-1 sets p=0.

## Configuration
`ARBITRO_LEITURAS_DATA_REG_EN`:
- **Defined:** `read_data_out` is registered (reset value 0). The return pipeline is lengthened by one stage, so `data_valid_out`/`read_id_out` arrive in cycle t+2+`MEM_LATENCY`, aligned with the registered data.
- **Undefined:** data passes combinationally, with the timing given above.

## Test plan
- **Reset defaults:** assert `rst` 2 cycles with `read_en_in`=8'hFF → all outputs 0. Release → first grant is `grant_out`=8'h01, then 8'h02, 8'h04 … 8'h80, 8'h01.
- **Single requester, held:** requester 3 only, held high with address vector 0x0A..0x11, `MEM_LATENCY`=1 → grant 8'h08 every other cycle, `read_addr_out` = that vector. One cycle after each grant, `data_valid_out`=8'h08 and `read_id_out`=3.
- **Pointer wrap:** p=6, `read_en_in`=8'b1000_0011 → grants in order 7, 0, 1, then p=2.
- **Pipelining:** `MEM_LATENCY`=3, requesters 0, 1, 2 pulse on consecutive cycles, memory returns distinct data D0, D1, D2 → `data_valid_out` = 1, 2, 4 on three consecutive cycles, each paired with its data.
- **Reset mid-flight:** `MEM_LATENCY`=4, two reads issued, `rst` pulsed before return → no `data_valid_out` afterwards.
- **Macro:** with `ARBITRO_LEITURAS_DATA_REG_EN` defined, repeat the single-requester case → valid and data one cycle later, still aligned.

Source files
------------

// File: rtl/arbitro_leituras_rr.sv
// Round-robin read arbiter: one requester per cycle drives the memory read-port bank; returns are tagged by id.
// Optional macro ARBITRO_LEITURAS_DATA_REG_EN registers read_data_out and adds one return stage to stay aligned.
module arbitro_leituras_rr #(
  parameter int NUM_READ_PORTS = 8,
  parameter int NUM_EA         = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int MEM_LATENCY    = 1,
  localparam int ID_WIDTH      = $clog2(NUM_EA)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_EA-1:0]                          read_en_in,
  input  logic [ADDR_WIDTH*NUM_READ_PORTS*NUM_EA-1:0] read_addr_in,
  output logic [NUM_EA-1:0]                          grant_out,
  output logic [ADDR_WIDTH*NUM_READ_PORTS-1:0]        read_addr_out,
  output logic                                       mem_read_en_out,
  input  logic [DATA_WIDTH*NUM_READ_PORTS-1:0]        mem_read_data_in,
  output logic [DATA_WIDTH*NUM_READ_PORTS-1:0]        read_data_out,
  output logic [NUM_EA-1:0]                          data_valid_out,
  output logic [ID_WIDTH-1:0]                        read_id_out
);

  localparam int VEC_W = ADDR_WIDTH * NUM_READ_PORTS;
`ifdef ARBITRO_LEITURAS_DATA_REG_EN
  localparam int PIPE_DEPTH = MEM_LATENCY + 1;
`else
  localparam int PIPE_DEPTH = MEM_LATENCY;
`endif
  localparam int LAST = PIPE_DEPTH - 1;

  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_EA-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0] grant_id_q;
  logic [VEC_W-1:0]    addr_q;
  logic                mem_en_q;
  logic [NUM_EA-1:0]   eligible;
  logic                win_found;
  logic [ID_WIDTH-1:0] win_id;
  logic [VEC_W-1:0]    req_vec [NUM_EA];

  generate
    for (genvar gi = 0; gi < NUM_EA; gi++) begin : g_slice
      assign req_vec[gi] = read_addr_in[gi*VEC_W +: VEC_W];
    end
  endgenerate

  // A requester still sees its own grant this cycle, so it must not win again.
  assign eligible = read_en_in & ~grant_q;

  always_comb begin
    int idx;
    logic [ID_WIDTH-1:0] idx_w;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    idx_w     = '0;
    for (int i = 0; i < NUM_EA; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_EA) idx = idx - NUM_EA;
      idx_w = ID_WIDTH'(idx);
      if (!win_found && eligible[idx_w]) begin
        win_found = 1'b1;
        win_id    = idx_w;
      end
    end
  end

  always_comb begin
    grant_d = '0;
    if (win_found) grant_d[win_id] = 1'b1;
    if (win_id == ID_WIDTH'(NUM_EA - 1)) ptr_d = '0;
    else                                 ptr_d = win_id + ID_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      addr_q     <= '0;
      mem_en_q   <= 1'b0;
    end else begin
      mem_en_q <= win_found;
      grant_q  <= grant_d;
      if (win_found) begin
        grant_id_q <= win_id;
        addr_q     <= req_vec[win_id];
        ptr_q      <= ptr_d;
      end
    end
  end

  assign grant_out       = grant_q;
  assign read_addr_out   = addr_q;
  assign mem_read_en_out = mem_en_q;

  // Return tag pipe: entry enters the cycle after issue, exits when memory data is valid.
  logic                pipe_valid_q [PIPE_DEPTH];
  logic [ID_WIDTH-1:0] pipe_id_q    [PIPE_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_id_q[i]    <= '0;
      end
    end else begin
      pipe_valid_q[0] <= mem_en_q;
      pipe_id_q[0]    <= grant_id_q;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_id_q[i]    <= pipe_id_q[i-1];
      end
    end
  end

  always_comb begin
    data_valid_out = '0;
    if (pipe_valid_q[LAST]) data_valid_out[pipe_id_q[LAST]] = 1'b1;
  end

  assign read_id_out = pipe_valid_q[LAST] ? pipe_id_q[LAST] : '0;

`ifdef ARBITRO_LEITURAS_DATA_REG_EN
  logic [DATA_WIDTH*NUM_READ_PORTS-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= mem_read_data_in;
  end

  assign read_data_out = data_q;
`else
  assign read_data_out = mem_read_data_in;
`endif

endmodule
